// File: rtl/clock_calendar_greg.sv
// Gregorian date keeper for the digital clock: advances day/month/year and day-of-week on the
// hour 23->0 rollover, validates loaded dates and computes the leap flag with a sequential mod-400 unit.
module clock_calendar_greg #(
   parameter int YEARRES   = 12,
   parameter int YEAR_BASE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           hour_in,
   input  logic [YEARRES+8:0]   date_in,
   input  logic [2:0]           dow_in,
   input  logic                 date_load,
   output logic [YEARRES+8:0]   date_out,
   output logic [2:0]           dow_out,
   output logic                 leap,
   output logic                 busy,
   output logic                 load_err,
   output logic                 day_p,
   output logic                 month_p,
   output logic                 year_p
);

   typedef enum logic [1:0] {IDLE, INIT, SUB, CHK} leapState_e;

   leapState_e          stateQ, stateD;
   logic [4:0]          dayQ, dayD;
   logic [3:0]          monthQ, monthD;
   logic [YEARRES-1:0]  yearQ, yearD;
   logic [2:0]          dowQ, dowD;
   logic [15:0]         rQ, rD;
   logic                leapQ, leapD;
   logic                loadErrQ, loadErrD;
   logic                dayPQ, dayPD;
   logic                monthPQ, monthPD;
   logic                yearPQ, yearPD;
   logic                pendingQ, pendingD;
   logic [4:0]          hourPrevQ;

   logic                tick;
   logic                loadOk;
   logic                chkLeap;
   logic [4:0]          loadDay;
   logic [3:0]          loadMonth;
   logic [YEARRES-1:0]  loadYear;

   function automatic logic [4:0] monthLen(input logic [3:0] m, input logic lp);
      case (m)
         4'd2:                      monthLen = lp ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   monthLen = 5'd30;
         default:                   monthLen = 5'd31;
      endcase
   endfunction

   assign loadDay   = date_in[YEARRES+8:YEARRES+4];
   assign loadMonth = date_in[YEARRES+3:YEARRES];
   assign loadYear  = date_in[YEARRES-1:0];

   assign tick    = (hour_in == 5'd0) && (hourPrevQ == 5'd23);
   assign busy    = (stateQ != IDLE);
   assign chkLeap = (rQ[1:0] == 2'b00) && (rQ != 16'd100) && (rQ != 16'd200) && (rQ != 16'd300);
   assign loadOk  = (loadMonth >= 4'd1) && (loadMonth <= 4'd12) && (loadDay != 5'd0) &&
                    (loadDay <= monthLen(loadMonth, 1'b1)) && (dow_in <= 3'd6);

   always_comb begin
      stateD   = stateQ;
      dayD     = dayQ;
      monthD   = monthQ;
      yearD    = yearQ;
      dowD     = dowQ;
      rD       = rQ;
      leapD    = leapQ;
      loadErrD = loadErrQ;
      pendingD = pendingQ;
      dayPD    = 1'b0;
      monthPD  = 1'b0;
      yearPD   = 1'b0;

      // SUB leaves as soon as the remainder is known to drop below 400 this cycle
      case (stateQ)
         INIT: begin
            rD     = 16'(YEAR_BASE) + 16'(yearQ);
            stateD = SUB;
         end
         SUB: begin
            if (rQ >= 16'd400) rD = rQ - 16'd400;
            if (rQ < 16'd800) stateD = CHK;
         end
         CHK: begin
            leapD  = chkLeap;
            stateD = IDLE;
            if (!chkLeap && (monthQ == 4'd2) && (dayQ == 5'd29)) begin
               dayD     = 5'd28;
               loadErrD = 1'b1;
            end
         end
         default: ;
      endcase

      if (date_load) begin
         pendingD = 1'b0;
         if (loadOk) begin
            dayD     = loadDay;
            monthD   = loadMonth;
            yearD    = loadYear;
            dowD     = dow_in;
            loadErrD = 1'b0;
            stateD   = INIT;
         end else begin
            loadErrD = 1'b1;
         end
      end else if (tick || pendingQ) begin
         if (busy) begin
            pendingD = 1'b1;
         end else begin
            pendingD = 1'b0;
            dayPD    = 1'b1;
            dowD     = (dowQ == 3'd6) ? 3'd0 : dowQ + 3'd1;
            if (dayQ < monthLen(monthQ, leapQ)) begin
               dayD = dayQ + 5'd1;
            end else begin
               dayD    = 5'd1;
               monthPD = 1'b1;
               if (monthQ < 4'd12) begin
                  monthD = monthQ + 4'd1;
               end else begin
                  monthD = 4'd1;
                  yearD  = yearQ + YEARRES'(1);
                  yearPD = 1'b1;
                  stateD = INIT;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ    <= INIT;
         dayQ      <= 5'd1;
         monthQ    <= 4'd1;
         yearQ     <= '0;
         dowQ      <= 3'd0;
         rQ        <= 16'd0;
         leapQ     <= 1'b0;
         loadErrQ  <= 1'b0;
         pendingQ  <= 1'b0;
         dayPQ     <= 1'b0;
         monthPQ   <= 1'b0;
         yearPQ    <= 1'b0;
         hourPrevQ <= 5'd0;
      end else begin
         stateQ    <= stateD;
         dayQ      <= dayD;
         monthQ    <= monthD;
         yearQ     <= yearD;
         dowQ      <= dowD;
         rQ        <= rD;
         leapQ     <= leapD;
         loadErrQ  <= loadErrD;
         pendingQ  <= pendingD;
         dayPQ     <= dayPD;
         monthPQ   <= monthPD;
         yearPQ    <= yearPD;
         hourPrevQ <= hour_in;
      end
   end

   assign date_out = {dayQ, monthQ, yearQ};
   assign dow_out  = dowQ;
   assign leap     = leapQ;
   assign load_err = loadErrQ;
   assign day_p    = dayPQ;
   assign month_p  = monthPQ;
   assign year_p   = yearPQ;

endmodule

// File: tb/tb_clock_calendar_greg.sv
// Randomised and directed checks of clock_calendar_greg against a calendar model built from
// plain date arithmetic and a busy-cycle countdown.
module tb_clock_calendar_greg;

   localparam int YR = 12;
   localparam int YB = 1900;
   localparam int DW = YR + 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [4:0]    hourIn = 5'd0;
   logic [DW-1:0] dateIn = '0;
   logic [2:0]    dowIn = 3'd0;
   logic          dateLoad = 1'b0;
   logic [DW-1:0] dateOut;
   logic [2:0]    dowOut;
   logic          leap, busy, loadErr, dayP, monthP, yearP;

   int checks = 0;
   int passes = 0;

   // model state
   int mDay = 1, mMonth = 1, mYear = 0, mDow = 0, mHourPrev = 0, mBusyCnt = 0;
   bit mLeap = 0, mErr = 0, mDayP = 0, mMonthP = 0, mYearP = 0, mPending = 0;

   always #5 clk = ~clk;

   clock_calendar_greg #(.YEARRES(YR), .YEAR_BASE(YB)) dut (
      .clk(clk), .rst(rst), .hour_in(hourIn), .date_in(dateIn), .dow_in(dowIn),
      .date_load(dateLoad), .date_out(dateOut), .dow_out(dowOut), .leap(leap),
      .busy(busy), .load_err(loadErr), .day_p(dayP), .month_p(monthP), .year_p(yearP)
   );

   function automatic bit isLeap(input int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int mLen(input int m, input bit lp);
      if (m == 2) return lp ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   // INIT + one SUB per 400 removed (at least one) + CHK
   function automatic int busyLen(input int yr);
      int q;
      q = (YB + yr) / 400;
      return 2 + ((q < 1) ? 1 : q);
   endfunction

   function automatic logic [DW-1:0] mkDate(input int d, input int m, input int y);
      return {5'(d), 4'(m), YR'(y)};
   endfunction

   task automatic modelStep(input bit r, input int hr, input bit ld, input logic [DW-1:0] d, input int dw);
      bit tick, wasBusy;
      int lDay, lMonth, lYear;
      if (r) begin
         mDay = 1; mMonth = 1; mYear = 0; mDow = 0; mHourPrev = 0; mLeap = 0; mErr = 0;
         mDayP = 0; mMonthP = 0; mYearP = 0; mPending = 0; mBusyCnt = busyLen(0);
         return;
      end
      tick = (hr == 0) && (mHourPrev == 23);
      mHourPrev = hr;
      mDayP = 0; mMonthP = 0; mYearP = 0;
      if (mBusyCnt == 1) begin
         mLeap = isLeap(YB + mYear);
         if (!mLeap && mMonth == 2 && mDay == 29) begin
            mDay = 28;
            mErr = 1;
         end
      end
      wasBusy = (mBusyCnt > 0);
      if (mBusyCnt > 0) mBusyCnt--;
      if (ld) begin
         mPending = 0;
         lDay = int'(d[DW-1 -: 5]);
         lMonth = int'(d[YR+3 -: 4]);
         lYear = int'(d[YR-1:0]);
         if (lMonth >= 1 && lMonth <= 12 && lDay >= 1 && lDay <= mLen(lMonth, 1) && dw <= 6) begin
            mDay = lDay; mMonth = lMonth; mYear = lYear; mDow = dw; mErr = 0;
            mBusyCnt = busyLen(lYear);
         end else begin
            mErr = 1;
         end
      end else if (tick || mPending) begin
         if (wasBusy) begin
            mPending = 1;
         end else begin
            mPending = 0;
            mDayP = 1;
            mDow = (mDow + 1) % 7;
            if (mDay < mLen(mMonth, isLeap(YB + mYear))) begin
               mDay++;
            end else begin
               mDay = 1;
               mMonthP = 1;
               if (mMonth == 12) begin
                  mMonth = 1;
                  mYear = (mYear + 1) % (1 << YR);
                  mYearP = 1;
                  mBusyCnt = busyLen(mYear);
               end else begin
                  mMonth++;
               end
            end
         end
      end
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic checkOutput();
      cmp("date", 32'(dateOut), 32'(mkDate(mDay, mMonth, mYear)));
      cmp("dow", 32'(dowOut), 32'(mDow));
      cmp("busy", 32'(busy), 32'(mBusyCnt > 0));
      cmp("leap", 32'(leap), 32'(mLeap));
      cmp("load_err", 32'(loadErr), 32'(mErr));
      cmp("pulses", {29'd0, dayP, monthP, yearP}, {29'd0, mDayP, mMonthP, mYearP});
   endtask

   task automatic applyStimulus(input bit r, input int hr, input bit ld, input logic [DW-1:0] d, input int dw);
      @(negedge clk);
      rst = r; hourIn = 5'(hr); dateLoad = ld; dateIn = d; dowIn = 3'(dw);
      modelStep(r, hr, ld, d, dw);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 300; i++) begin
         if (busy === 1'b0) return;
         applyStimulus(0, 12, 0, '0, 0);
      end
      checks++;
      $display("[TB] FAIL waitIdle: busy still %0d, required 0", busy);
   endtask

   task automatic rollover();
      applyStimulus(0, 23, 0, '0, 0);
      applyStimulus(0, 0, 0, '0, 0);
   endtask

   initial begin
      int hr, d, m, y, dw;

      applyStimulus(1, 12, 0, '0, 0);
      cmp("T1 busy after reset", 32'(busy), 32'd1);
      waitIdle();
      cmp("T1 date", 32'(dateOut), 32'(mkDate(1, 1, 0)));
      cmp("T1 leap 1900", 32'(leap), 32'd0);
      cmp("T1 load_err", 32'(loadErr), 32'd0);

      applyStimulus(0, 12, 1, mkDate(28, 2, 100), 2);
      waitIdle();
      rollover();
      cmp("T2 date 29/2/2000", 32'(dateOut), 32'(mkDate(29, 2, 100)));
      cmp("T2 dow", 32'(dowOut), 32'd3);
      cmp("T2 day_p", 32'(dayP), 32'd1);
      cmp("T2 leap 2000", 32'(leap), 32'd1);
      rollover();
      cmp("T2 date 1/3", 32'(dateOut), 32'(mkDate(1, 3, 100)));
      cmp("T2 month_p", 32'(monthP), 32'd1);

      applyStimulus(0, 12, 1, mkDate(28, 2, 200), 0);
      waitIdle();
      rollover();
      cmp("T3 date 1/3/2100", 32'(dateOut), 32'(mkDate(1, 3, 200)));
      applyStimulus(0, 12, 1, mkDate(28, 2, 124), 0);
      waitIdle();
      rollover();
      cmp("T3 date 29/2/2024", 32'(dateOut), 32'(mkDate(29, 2, 124)));

      applyStimulus(0, 12, 1, mkDate(31, 12, 4095), 6);
      waitIdle();
      rollover();
      cmp("T4 date wrap", 32'(dateOut), 32'(mkDate(1, 1, 0)));
      cmp("T4 dow", 32'(dowOut), 32'd0);
      cmp("T4 pulses", {29'd0, dayP, monthP, yearP}, 32'd7);
      cmp("T4 busy", 32'(busy), 32'd1);

      applyStimulus(0, 12, 1, mkDate(29, 2, 123), 0);
      waitIdle();
      cmp("T5 feb29 corrected", 32'(dateOut), 32'(mkDate(28, 2, 123)));
      cmp("T5 load_err", 32'(loadErr), 32'd1);
      applyStimulus(0, 12, 1, mkDate(31, 4, 123), 0);
      cmp("T5 31/4 rejected", 32'(dateOut), 32'(mkDate(28, 2, 123)));
      applyStimulus(0, 12, 1, mkDate(5, 13, 123), 0);
      cmp("T5 month13 err", 32'(loadErr), 32'd1);
      applyStimulus(0, 12, 1, mkDate(15, 6, 123), 0);
      cmp("T5 valid clears err", 32'(loadErr), 32'd0);
      waitIdle();

      applyStimulus(0, 23, 1, mkDate(10, 5, 100), 1);
      applyStimulus(0, 0, 0, '0, 0);
      waitIdle();
      applyStimulus(0, 12, 0, '0, 0);
      applyStimulus(0, 12, 0, '0, 0);
      cmp("T6 pending advance", 32'(dateOut), 32'(mkDate(11, 5, 100)));
      cmp("T6 pending dow", 32'(dowOut), 32'd2);
      applyStimulus(0, 23, 0, '0, 0);
      applyStimulus(0, 0, 1, mkDate(20, 7, 300), 4);
      waitIdle();
      applyStimulus(0, 12, 0, '0, 0);
      cmp("T6 load beats tick", 32'(dateOut), 32'(mkDate(20, 7, 300)));
      applyStimulus(0, 12, 1, mkDate(1, 1, 4000), 3);
      for (int i = 0; i < 4; i++) applyStimulus(0, 12, 0, '0, 0);
      applyStimulus(1, 12, 0, '0, 0);
      cmp("T6 rst date", 32'(dateOut), 32'(mkDate(1, 1, 0)));
      cmp("T6 rst busy", 32'(busy), 32'd1);
      waitIdle();

      hr = 12;
      for (int c = 0; c < 5000; c++) begin
         hr = (hr + 1) % 24;
         if ($urandom_range(0, 49) == 0) hr = int'($urandom_range(0, 23));
         if ($urandom_range(0, 999) == 0) begin
            applyStimulus(1, hr, 0, '0, 0);
         end else if ($urandom_range(0, 29) == 0) begin
            d = int'($urandom_range(0, 31));
            m = int'($urandom_range(0, 13));
            y = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0) begin
               d = int'($urandom_range(27, 31));
               m = ($urandom_range(0, 1) == 1) ? 2 : 12;
            end
            dw = ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, 6));
            applyStimulus(0, hr, 1, mkDate(d, m, y), dw);
         end else begin
            applyStimulus(0, hr, 0, '0, 0);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
